// File: rtl/display_pkg.sv
// Shared types and seven-segment constants for the BCD display path.
package display_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Active-low codes, bit0 = seg a ... bit6 = seg g.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  localparam logic [0:9][SEG_W-1:0] SEG_DIGIT = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-to-segment encoder with blank override.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0]       digit_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_c
);

  // Blank wins; out-of-range nibbles also show blank.
  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank_i && (digit_i <= 4'd9)) begin
      seg_c = SEG_DIGIT[digit_i];
    end
  end

endmodule

// File: rtl/bcd_hex_display.sv
// Sequential double-dabble binary-to-BCD converter driving four 7-segment digits.
module bcd_hex_display
  import display_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 64,
  parameter int unsigned BIN_BITS = 14,
  parameter int unsigned MAX_VAL  = 9999,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] reg_out,
  output logic [SEG_W-1:0]    HEX0,
  output logic [SEG_W-1:0]    HEX1,
  output logic [SEG_W-1:0]    HEX2,
  output logic [SEG_W-1:0]    HEX3,
  output logic                busy,
  output logic                ovf
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_BITS + 1);

  state_e                            state_q, state_d;
  logic [IN_WIDTH-1:0]               last_val_q, last_val_d;
  logic                              first_q, first_d;
  logic [BIN_BITS-1:0]               bin_q, bin_d;
  logic [BCD_W-1:0]                  bcd_q, bcd_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              ovf_pend_q, ovf_pend_d;
  logic                              busy_q, busy_d;
  logic                              ovf_q, ovf_d;
  logic [BCD_DIGITS-1:0][SEG_W-1:0]  hex_q, hex_d;

  logic [BCD_W-1:0]                  bcd_adj_c;
  logic [BCD_DIGITS-1:0]             blank_c;
  logic [BCD_DIGITS-1:0][SEG_W-1:0]  seg_c;

  // Add-3 correction on every nibble that is 5 or more before the shift.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking: a digit blanks when it and all higher digits are zero.
  always_comb begin
    blank_c = '0;
    for (int unsigned i = 1; i < BCD_DIGITS; i++) begin
      blank_c[i] = (BLANK_LZ != 0) && ((bcd_q >> (4*i)) == '0);
    end
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_seg
    seg7_encode u_seg7_encode (
      .digit_i (bcd_q[4*g +: 4]),
      .blank_i (blank_c[g]),
      .seg_c   (seg_c[g])
    );
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    first_d    = first_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    hex_d      = hex_q;

    case (state_q)
      IDLE: begin
        if ((reg_out != last_val_q) || first_q) begin
          last_val_d = reg_out;
          first_d    = 1'b0;
          busy_d     = 1'b1;
          if (reg_out > IN_WIDTH'(MAX_VAL)) begin
            ovf_pend_d = 1'b1;
            state_d    = DONE;
          end else begin
            ovf_pend_d = 1'b0;
            bin_d      = reg_out[BIN_BITS-1:0];
            bcd_d      = '0;
            cnt_d      = CNT_W'(BIN_BITS);
            state_d    = SHIFT;
          end
        end
      end

      SHIFT: begin
        bcd_d = {bcd_adj_c[BCD_W-2:0], bin_q[BIN_BITS-1]};
        bin_d = {bin_q[BIN_BITS-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
          hex_d[i] = ovf_pend_q ? SEG_DASH : seg_c[i];
        end
        ovf_d   = ovf_pend_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_val_q <= '0;
      first_q    <= 1'b1;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hex_q      <= {BCD_DIGITS{SEG_BLANK}};
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      first_q    <= first_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      hex_q      <= hex_d;
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_hex_display.sv
// Scoreboard bench for bcd_hex_display: expected displays queued at drive time.
module tb_bcd_hex_display;

  logic        clk;
  logic        rst;
  logic [63:0] reg_out;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic        busy, ovf;

  typedef struct {
    logic [63:0] val;
    logic [6:0]  h0, h1, h2, h3;
    logic        ovf;
    int          lat;
    int          drv;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        prev_busy = 1'b0;
  logic [63:0] last_applied = 64'd0;

  bcd_hex_display #(
    .IN_WIDTH (64),
    .BIN_BITS (14),
    .MAX_VAL  (9999),
    .BLANK_LZ (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .reg_out (reg_out),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .busy    (busy),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic exp_t model(input logic [63:0] v, input int lat, input int drv);
    exp_t e;
    int   n, d0, d1, d2, d3;
    logic b1, b2, b3;
    e.val = v;
    e.lat = lat;
    e.drv = drv;
    if (v > 64'd9999) begin
      e.h0 = 7'h3F; e.h1 = 7'h3F; e.h2 = 7'h3F; e.h3 = 7'h3F;
      e.ovf = 1'b1;
    end else begin
      n  = int'(v[31:0]);
      d0 = n % 10;
      d1 = (n / 10) % 10;
      d2 = (n / 100) % 10;
      d3 = (n / 1000) % 10;
      b3 = (d3 == 0);
      b2 = b3 && (d2 == 0);
      b1 = b2 && (d1 == 0);
      e.h0 = seg_of(d0);
      e.h1 = b1 ? 7'h7F : seg_of(d1);
      e.h2 = b2 ? 7'h7F : seg_of(d2);
      e.h3 = b3 ? 7'h7F : seg_of(d3);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Output monitor: a busy falling edge marks a display update.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_update", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            chk($sformatf("hex0_%0d", e.val), 64'(HEX0), 64'(e.h0));
            chk($sformatf("hex1_%0d", e.val), 64'(HEX1), 64'(e.h1));
            chk($sformatf("hex2_%0d", e.val), 64'(HEX2), 64'(e.h2));
            chk($sformatf("hex3_%0d", e.val), 64'(HEX3), 64'(e.h3));
            chk($sformatf("ovf_%0d", e.val), 64'(ovf), 64'(e.ovf));
            chk($sformatf("latency_%0d", e.val), 64'(cyc - e.drv), 64'(e.lat));
          end
        end
        prev_busy = busy;
      end
    end
  end

  task automatic push(input logic [63:0] v, input int lat);
    sb_q.push_back(model(v, lat, cyc));
  endtask

  // Drive a new value; only a changed value triggers a conversion.
  task automatic apply(input logic [63:0] v);
    @(negedge clk);
    reg_out = v;
    if (v != last_applied) push(v, (v > 64'd9999) ? 2 : 16);
    last_applied = v;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a, b, t;
    rst     = 1'b1;
    reg_out = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_hex0", 64'(HEX0), 64'h7F);
    chk("rst_hex1", 64'(HEX1), 64'h7F);
    chk("rst_hex2", 64'(HEX2), 64'h7F);
    chk("rst_hex3", 64'(HEX3), 64'h7F);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // Release: first-conversion of 0.
    rst = 1'b0;
    push(64'd0, 16);
    @(posedge clk);
    #1;
    chk("busy_after_release", 64'(busy), 64'd1);
    wait_drain(100);

    apply(64'd1234);        wait_drain(100);
    apply(64'd9999);        wait_drain(100);
    apply(64'd987);         wait_drain(100);
    apply(64'd10000);       wait_drain(100);
    apply(64'h1_0000_0005); wait_drain(100);

    // Change mid-conversion: 34 is picked up only after 21 is shown.
    apply(64'd21);
    repeat (5) @(negedge clk);
    reg_out = 64'd34;
    push(64'd34, 16 + 16 - 5);
    last_applied = 64'd34;
    wait_drain(100);

    // Reset in the middle of a conversion.
    apply(64'd5678);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_hex0", 64'(HEX0), 64'h7F);
    chk("midrst_hex1", 64'(HEX1), 64'h7F);
    chk("midrst_hex2", 64'(HEX2), 64'h7F);
    chk("midrst_hex3", 64'(HEX3), 64'h7F);
    chk("midrst_busy", 64'(busy), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push(64'd5678, 16);
    wait_drain(100);

    // Fibonacci sequence, one value every 20 cycles.
    a = 0;
    b = 1;
    while (a <= 10946) begin
      apply(64'(a));
      repeat (19) @(negedge clk);
      t = a + b;
      a = b;
      b = t;
    end
    wait_drain(100);
    apply(64'd0);
    wait_drain(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
